// File: rtl/risc16p.sv
// risc16p: 16-bit three-stage (IF / ID / EX+WB) RISC core.
// Full 16-op ALU, beqz/dec_bnez/bmi/bpl/j branches resolved in ID with one
// delay slot, memory wait-state handshakes that stall the whole pipeline,
// and cycle/retire/stall performance counters.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   i_addr, i_oe, i_din, i_ready instruction fetch port
//   d_addr, d_oe, d_we, d_dout,
//   d_din, d_ready               data port (d_we: 11 word, 01 high/even, 10 low/odd)
//   cycle_cnt, instret_cnt,
//   stall_cnt                    performance counters, wrap at 2^CNT_W
module risc16p #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [15:0]      i_addr,
    output logic             i_oe,
    input  logic [15:0]      i_din,
    input  logic             i_ready,
    output logic [15:0]      d_addr,
    output logic             d_oe,
    output logic [1:0]       d_we,
    output logic [15:0]      d_dout,
    input  logic [15:0]      d_din,
    input  logic             d_ready,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [15:0] pc, pc_id, ir_id, ir_ex, a_ex, b_ex, wb_val;
    logic [2:0]  wb_reg;
    logic        wb_en;
    logic [15:0] rf [0:7];

    function automatic logic [15:0] alu(input logic [3:0] code,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (code)
            4'h0:    return a;
            4'h1:    return b;
            4'h2:    return ~b;
            4'h3:    return a ^ b;
            4'h4:    return a + b;
            4'h5:    return a - b;
            4'h6:    return {b[7:0], 8'h00};
            4'h7:    return {8'h00, b[15:8]};
            4'h8:    return {b[14:0], 1'b0};
            4'h9:    return {1'b0, b[15:1]};
            4'hA:    return a & b;
            4'hB:    return a | b;
            4'hC:    return {a[13:0], 2'b00};
            4'hD:    return {2'b00, a[15:2]};
            4'hE:    return b & 16'h00FE;
            default: return {8'h00, b[15:8] & 8'hFE};
        endcase
    endfunction

    // Does this instruction write its rX field? Nops, stores and branches
    // other than dec_bnez do not, so they never forward either.
    function automatic logic writes_rx(input logic [15:0] ir);
        if (ir == 16'h0000)
            return 1'b0;
        else if (ir[15:11] == 5'b00000)
            return !ir[4] || (ir[4:0] == 5'b10001) || (ir[4:0] == 5'b10011);
        else if (!ir[15])
            return 1'b1;
        else
            return ir[15:11] == 5'b10001;
    endfunction

    // ---------------- EX stage ----------------
    logic [4:0]  op_ex, fn_ex;
    logic        r_ex, sw_ex, lw_ex, sbu_ex, lbu_ex, mem_ex, ex_wr, ex_nop;
    logic [15:0] ex_result;
    logic        oe_int;
    logic [1:0]  we_int;
    logic        stall;

    assign op_ex  = ir_ex[15:11];
    assign fn_ex  = ir_ex[4:0];
    assign r_ex   = (op_ex == 5'b00000);
    assign sw_ex  = r_ex && (fn_ex == 5'b10000);
    assign lw_ex  = r_ex && (fn_ex == 5'b10001);
    assign sbu_ex = r_ex && (fn_ex == 5'b10010);
    assign lbu_ex = r_ex && (fn_ex == 5'b10011);
    assign mem_ex = sw_ex || lw_ex || sbu_ex || lbu_ex;
    assign ex_wr  = writes_rx(ir_ex);
    assign ex_nop = (ir_ex == 16'h0000) ||
                    (op_ex[4] && !(op_ex[3:2] == 2'b00 || op_ex == 5'b11000));

    always_comb begin
        ex_result = 16'h0000;
        if (r_ex) begin
            if (!fn_ex[4])
                ex_result = alu(fn_ex[3:0], a_ex, b_ex);
            else if (lw_ex)
                ex_result = d_din;
            else if (lbu_ex)
                ex_result = {8'h00, b_ex[0] ? d_din[7:0] : d_din[15:8]};
        end else if (op_ex == 5'b10001) begin
            ex_result = a_ex - 16'd1;
        end else if (!op_ex[4]) begin
            ex_result = alu(op_ex[3:0], a_ex, b_ex);
        end
    end

    assign oe_int = lw_ex || lbu_ex;
    assign we_int = sw_ex ? 2'b11 : (sbu_ex ? (b_ex[0] ? 2'b10 : 2'b01) : 2'b00);
    // Stall uses the ungated strobes; ir_ex is already clear during reset.
    assign stall  = !i_ready || ((oe_int || (we_int != 2'b00)) && !d_ready);

    assign i_addr = pc;
    assign i_oe   = rst_n;
    assign d_oe   = rst_n && oe_int;
    assign d_we   = rst_n ? we_int : 2'b00;
    assign d_addr = mem_ex ? b_ex : 16'h0000;
    always_comb begin
        d_dout = 16'h0000;
        if (sw_ex)
            d_dout = a_ex;
        else if (sbu_ex)
            d_dout = b_ex[0] ? {8'h00, a_ex[7:0]} : {a_ex[7:0], 8'h00};
    end

    // ---------------- ID stage ----------------
    logic [4:0]  op_id;
    logic [2:0]  rx_id, ry_id;
    logic [15:0] rx_val, ry_val, imm16, b_id, sext8, target;
    logic        taken;

    assign op_id = ir_id[15:11];
    assign rx_id = ir_id[10:8];
    assign ry_id = ir_id[7:5];
    assign sext8 = {{8{ir_id[7]}}, ir_id[7:0]};

    always_comb begin
        if (ex_wr && ir_ex[10:8] == rx_id)
            rx_val = ex_result;
        else if (wb_en && wb_reg == rx_id)
            rx_val = wb_val;
        else
            rx_val = rf[rx_id];
    end

    always_comb begin
        if (ex_wr && ir_ex[10:8] == ry_id)
            ry_val = ex_result;
        else if (wb_en && wb_reg == ry_id)
            ry_val = wb_val;
        else
            ry_val = rf[ry_id];
    end

    assign imm16  = (op_id == 5'b00100) ? sext8 : {8'h00, ir_id[7:0]};
    assign b_id   = (op_id == 5'b00000) ? ry_val : imm16;
    assign target = pc_id + 16'd2 + sext8;

    always_comb begin
        case (op_id)
            5'b10000: taken = (rx_val == 16'h0000);
            5'b10001: taken = (rx_val != 16'h0001);
            5'b10010: taken = rx_val[15];
            5'b10011: taken = !rx_val[15];
            5'b11000: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            pc_id  <= RESET_PC;
            ir_id  <= 16'h0000;
            ir_ex  <= 16'h0000;
            a_ex   <= 16'h0000;
            b_ex   <= 16'h0000;
            wb_en  <= 1'b0;
            wb_reg <= 3'd0;
            wb_val <= 16'h0000;
            for (int i = 0; i < 8; i++)
                rf[i] <= 16'h0000;
        end else if (!stall) begin
            pc     <= taken ? target : pc + 16'd2;
            pc_id  <= pc;
            ir_id  <= i_din;
            ir_ex  <= ir_id;
            a_ex   <= rx_val;
            b_ex   <= b_id;
            wb_en  <= ex_wr;
            wb_reg <= ir_ex[10:8];
            wb_val <= ex_result;
            if (wb_en)
                rf[wb_reg] <= wb_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            else if (!ex_nop)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_risc16p.sv
module tb_risc16p;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_addr, i_din, d_addr, d_dout, d_din;
    logic        i_oe, i_ready, d_oe, d_ready;
    logic [1:0]  d_we;
    logic [31:0] cycle_cnt, instret_cnt, stall_cnt;

    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];

    int n_checks = 0;
    int n_pass   = 0;
    int put_idx  = 128;

    assign i_din = imem[i_addr[8:1]];
    assign d_din = dmem[d_addr[8:1]];

    risc16p #(.RESET_PC(16'h0100), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din), .i_ready(i_ready),
        .d_addr(d_addr), .d_oe(d_oe), .d_we(d_we), .d_dout(d_dout),
        .d_din(d_din), .d_ready(d_ready),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] insn;
        logic [15:0] exp;
    } alu_vec_t;

    function automatic logic [15:0] mk_r(input logic [2:0] rx, input logic [2:0] ry,
                                         input logic [4:0] fn);
        return {5'b00000, rx, ry, fn};
    endfunction

    function automatic logic [15:0] mk_i(input logic [4:0] op, input logic [2:0] rx,
                                         input logic [7:0] imm);
        return {op, rx, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic new_prog();
        for (int i = 0; i < 256; i++)
            imem[i] = 16'h0000;
        put_idx = 128;
    endtask

    task automatic put(input logic [15:0] insn);
        imem[put_idx] = insn;
        put_idx++;
    endtask

    // One clock: commit any completing store, then advance to the next negedge.
    task automatic step();
        int idx;
        if (rst_n && d_ready && d_we != 2'b00) begin
            idx = int'(d_addr[8:1]);
            if (d_we[0]) dmem[idx][15:8] = d_dout[15:8];
            if (d_we[1]) dmem[idx][7:0]  = d_dout[7:0];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_ready = 1'b1;
        d_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    alu_vec_t    vecs [23];
    logic [15:0] jexp [9];

    initial begin
        rst_n   = 1'b0;
        i_ready = 1'b1;
        d_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = 16'h0000;
        end

        vecs[0]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h00), 16'h1234};
        vecs[1]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h01), 16'h0F0F};
        vecs[2]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h02), 16'hF0F0};
        vecs[3]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h03), 16'h1D3B};
        vecs[4]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h04), 16'h2143};
        vecs[5]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h05), 16'h0325};
        vecs[6]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h06), 16'h0F00};
        vecs[7]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h07), 16'h000F};
        vecs[8]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h08), 16'h1E1E};
        vecs[9]  = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h09), 16'h0787};
        vecs[10] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0A), 16'h0204};
        vecs[11] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0B), 16'h1F3F};
        vecs[12] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0C), 16'h48D0};
        vecs[13] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0D), 16'h048D};
        vecs[14] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0E), 16'h000E};
        vecs[15] = '{16'h1234, 16'h0F0F, mk_r(3'd1, 3'd2, 5'h0F), 16'h000E};
        vecs[16] = '{16'h0001, 16'h0002, mk_r(3'd1, 3'd2, 5'h05), 16'hFFFF};
        vecs[17] = '{16'hFFFF, 16'h0002, mk_r(3'd1, 3'd2, 5'h04), 16'h0001};
        vecs[18] = '{16'h1000, 16'h0000, mk_i(5'b00100, 3'd1, 8'hFE), 16'h0FFE};
        vecs[19] = '{16'h1000, 16'h0000, mk_i(5'b00101, 3'd1, 8'hFF), 16'h0F01};
        vecs[20] = '{16'h1000, 16'h0000, mk_i(5'b01011, 3'd1, 8'h80), 16'h1080};
        vecs[21] = '{16'h1000, 16'h0000, mk_i(5'b01110, 3'd1, 8'hFF), 16'h00FE};
        vecs[22] = '{16'h1000, 16'h0000, mk_i(5'b00110, 3'd1, 8'hAB), 16'hAB00};

        jexp = '{16'h0100, 16'h0102, 16'h0104, 16'h0100, 16'h0102,
                 16'h0104, 16'h0100, 16'h0102, 16'h0104};

        // ALU table: build r1=a, r2=b, run the op on r1, store r1 to 0x0300.
        for (int i = 0; i < 23; i++) begin
            new_prog();
            put(mk_i(5'b00110, 3'd1, vecs[i].a[15:8]));
            put(mk_i(5'b01011, 3'd1, vecs[i].a[7:0]));
            put(mk_i(5'b00110, 3'd2, vecs[i].b[15:8]));
            put(mk_i(5'b01011, 3'd2, vecs[i].b[7:0]));
            put(vecs[i].insn);
            put(mk_i(5'b00110, 3'd3, 8'h03));
            put(mk_r(3'd1, 3'd3, 5'b10000));
            dmem[128] = 16'hDEAD;
            do_reset();
            run(14);
            check($sformatf("alu_vec%0d", i), {16'h0, dmem[128]}, {16'h0, vecs[i].exp});
        end

        // Forwarding chain
        new_prog();
        put(mk_i(5'b00100, 3'd1, 8'd5));
        put(mk_r(3'd1, 3'd1, 5'h04));
        put(mk_r(3'd1, 3'd1, 5'h04));
        put(16'h0000);
        put(16'h0000);
        put(mk_i(5'b00110, 3'd3, 8'h03));
        put(mk_r(3'd1, 3'd3, 5'b10000));
        dmem[128] = 16'hDEAD;
        do_reset();
        run(5);
        check("fwd_instret", instret_cnt, 32'd3);
        check("fwd_stall", stall_cnt, 32'd0);
        check("fwd_cycle", cycle_cnt, 32'd5);
        run(10);
        check("fwd_r1", {16'h0, dmem[128]}, 32'd20);
        check("fwd_instret_end", instret_cnt, 32'd5);

        // dec_bnez loop
        new_prog();
        put(mk_i(5'b00001, 3'd2, 8'd3));
        put(mk_i(5'b00001, 3'd4, 8'd0));
        put(mk_i(5'b00100, 3'd4, 8'd1));
        put({5'b10001, 3'd2, 8'hFC});
        put(mk_i(5'b00100, 3'd5, 8'd1));
        put(mk_i(5'b00110, 3'd3, 8'h03));
        put(mk_r(3'd4, 3'd3, 5'b10000));
        put(mk_i(5'b00100, 3'd3, 8'd2));
        put(mk_r(3'd5, 3'd3, 5'b10000));
        put(mk_i(5'b00100, 3'd3, 8'd2));
        put(mk_r(3'd2, 3'd3, 5'b10000));
        dmem[128] = 16'hDEAD; dmem[129] = 16'hDEAD; dmem[130] = 16'hDEAD;
        do_reset();
        run(30);
        check("loop_body_count", {16'h0, dmem[128]}, 32'd3);
        check("loop_slot_count", {16'h0, dmem[129]}, 32'd3);
        check("loop_r2_exit", {16'h0, dmem[130]}, 32'd0);
        check("loop_instret", instret_cnt, 32'd17);

        // Byte store / load
        new_prog();
        put(mk_i(5'b00110, 3'd3, 8'h12));
        put(mk_i(5'b01011, 3'd3, 8'hAB));
        put(mk_i(5'b00110, 3'd4, 8'h02));
        put(mk_i(5'b01011, 3'd4, 8'h01));
        put(mk_r(3'd3, 3'd4, 5'b10010));
        put(mk_i(5'b00100, 3'd4, 8'hFF));
        put(mk_r(3'd5, 3'd4, 5'b10011));
        put(mk_i(5'b00110, 3'd6, 8'h03));
        put(mk_r(3'd5, 3'd6, 5'b10000));
        dmem[0] = 16'h5678; dmem[128] = 16'hDEAD;
        do_reset();
        run(6);
        check("sbu_we", {30'h0, d_we}, 32'h2);
        check("sbu_dout", {16'h0, d_dout}, 32'h00AB);
        check("sbu_addr", {16'h0, d_addr}, 32'h0201);
        run(2);
        check("lbu_oe", {31'h0, d_oe}, 32'h1);
        check("lbu_addr", {16'h0, d_addr}, 32'h0200);
        run(8);
        check("lbu_result", {16'h0, dmem[128]}, 32'h0056);
        check("sbu_mem", {16'h0, dmem[0]}, 32'h56AB);

        // Reset in the middle of a stalled store, then boot
        dmem[0] = 16'h5678;
        do_reset();
        run(6);
        d_ready = 1'b0;
        step();
        check("held_we", {30'h0, d_we}, 32'h2);
        check("held_addr", {16'h0, d_addr}, 32'h0201);
        check("held_stall_cnt", stall_cnt, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_i_addr", {16'h0, i_addr}, 32'h0100);
        check("rst_i_oe", {31'h0, i_oe}, 32'h0);
        check("rst_d_we", {30'h0, d_we}, 32'h0);
        check("rst_d_oe", {31'h0, d_oe}, 32'h0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instret", instret_cnt, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        @(negedge clk);
        d_ready = 1'b1;
        rst_n   = 1'b1;
        check("boot_i_addr", {16'h0, i_addr}, 32'h0100);
        check("boot_i_oe", {31'h0, i_oe}, 32'h1);
        step();
        check("boot_next_addr", {16'h0, i_addr}, 32'h0102);
        check("aborted_store", {16'h0, dmem[0]}, 32'h5678);

        // Wait states on a load and on fetch
        new_prog();
        put(mk_i(5'b00110, 3'd3, 8'h03));
        put(mk_r(3'd1, 3'd3, 5'b10001));
        put(mk_i(5'b00100, 3'd1, 8'd1));
        put(mk_i(5'b00110, 3'd4, 8'h03));
        put(mk_i(5'b01011, 3'd4, 8'h02));
        put(mk_r(3'd1, 3'd4, 5'b10000));
        dmem[128] = 16'hBEEF; dmem[129] = 16'hDEAD;
        do_reset();
        run(3);
        check("lw_oe", {31'h0, d_oe}, 32'h1);
        check("lw_addr", {16'h0, d_addr}, 32'h0300);
        check("lw_pc", {16'h0, i_addr}, 32'h0106);
        i_ready = 1'b0;
        d_ready = 1'b0;
        step();
        i_ready = 1'b1;
        run(2);
        check("dwait_pc", {16'h0, i_addr}, 32'h0106);
        check("dwait_addr", {16'h0, d_addr}, 32'h0300);
        check("dwait_stall_cnt", stall_cnt, 32'd3);
        d_ready = 1'b1;
        step();
        check("dwait_release_pc", {16'h0, i_addr}, 32'h0108);
        i_ready = 1'b0;
        run(2);
        check("iwait_pc", {16'h0, i_addr}, 32'h0108);
        check("iwait_stall_cnt", stall_cnt, 32'd5);
        i_ready = 1'b1;
        run(10);
        check("lw_value", {16'h0, dmem[129]}, 32'hBEF0);
        check("final_stall_cnt", stall_cnt, 32'd5);

        // bmi / bpl
        new_prog();
        put(mk_i(5'b00110, 3'd1, 8'h80));
        put({5'b10010, 3'd1, 8'd4});
        put(mk_i(5'b00100, 3'd5, 8'd1));
        put(mk_i(5'b00100, 3'd6, 8'd1));
        put({5'b10011, 3'd1, 8'd4});
        put(mk_i(5'b00100, 3'd5, 8'd1));
        put(mk_i(5'b00100, 3'd7, 8'd1));
        put(mk_i(5'b00110, 3'd3, 8'h03));
        put(mk_r(3'd5, 3'd3, 5'b10000));
        put(mk_i(5'b00100, 3'd3, 8'd2));
        put(mk_r(3'd6, 3'd3, 5'b10000));
        put(mk_i(5'b00100, 3'd3, 8'd2));
        put(mk_r(3'd7, 3'd3, 5'b10000));
        dmem[128] = 16'hDEAD; dmem[129] = 16'hDEAD; dmem[130] = 16'hDEAD;
        do_reset();
        run(25);
        check("br_delay_slots", {16'h0, dmem[128]}, 32'd2);
        check("bmi_taken_skip", {16'h0, dmem[129]}, 32'd0);
        check("bpl_not_taken", {16'h0, dmem[130]}, 32'd1);

        // j -4 loop with delay slot
        new_prog();
        put(mk_i(5'b00100, 3'd1, 8'd1));
        put({5'b11000, 3'd0, 8'hFC});
        put(mk_i(5'b00100, 3'd2, 8'd1));
        do_reset();
        for (int c = 0; c < 9; c++) begin
            check($sformatf("j_fetch%0d", c), {16'h0, i_addr}, {16'h0, jexp[c]});
            step();
        end
        check("j_instret", instret_cnt, 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/risc16p.md
# risc16p

Parametrised successor of the 16-bit three-stage (IF / ID / EX+WB) RISC core. Executes the same 16-bit instruction format with the full 16-op ALU, adds `bmi`/`bpl`/`j` branches, memory wait-state handshakes (`i_ready`/`d_ready`) that stall the whole pipeline, and cycle/retire/stall performance counters. It drops in where the current core sits, between instruction memory and data memory.

## Interface
- `RESET_PC`, 16'h0000: fetch address after reset.
- `CNT_W`, 32: width of each performance counter (8..64).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_addr` out 16: fetch address (PC).
- `i_oe` out 1: fetch enable.
- `i_din` in 16: instruction word.
- `i_ready` in 1: `i_din` valid this cycle.
- `d_addr` out 16: data address.
- `d_oe` out 1: load request.
- `d_we` out 2: byte write enables. `2'b11` = word; `2'b01` = even/high byte on `d_dout[15:8]`; `2'b10` = odd/low byte on `d_dout[7:0]`.
- `d_dout` out 16: store data.
- `d_din` in 16: load data.
- `d_ready` in 1: data access completes this cycle.
- `cycle_cnt` out `CNT_W`: cycles since reset.
- `instret_cnt` out `CNT_W`: retired non-nop instructions.
- `stall_cnt` out `CNT_W`: stalled cycles.

## Operation
**Instruction fields:** `op=[15:11]`, `rX=[10:8]`, `rY=[7:5]`, `imm=[7:0]`, `fn=[4:0]`.

**R-type (`op=00000`)**
- `fn[4]=0`: `rX <= ALU(fn[3:0], rX, rY)`.
- `fn=10000` sw, `10001` lw, `10010` sbu, `10011` lbu. Address is `rY`; data register is `rX`.
- lbu takes `d_din[15:8]` for an even address and `d_din[7:0]` for an odd address, zero-extended.

**I-type (`op=0xxxx`, not 00000)**
- `rX <= ALU(op[3:0], rX, imm16)`.
- `imm16` is sign-extended for `op=00100`, zero-extended otherwise.

**ALU ops** (`a` = rX, `b` = rY or imm)

| Code | Result |
|---|---|
| 0 | a |
| 1 | b |
| 2 | ~b |
| 3 | a^b |
| 4 | a+b |
| 5 | a−b |
| 6 | b<<8 |
| 7 | b>>8 |
| 8 | b<<1 |
| 9 | b>>1 |
| A | a&b |
| B | a\|b |
| C | a<<2 |
| D | a>>2 |
| E | b&00FE |
| F | (b>>8)&00FE |

All shifts are logical; all arithmetic is mod 2^16.

**Branches**
- Resolved in ID using forwarded rX.
- Target = branch address + 2 + sext(imm).
- `10000` beqz: taken if rX==0.
- `10001` dec_bnez: writes rX−1, taken if rX−1≠0.
- `10010` bmi: taken if rX[15].
- `10011` bpl: taken if !rX[15].
- `11000` j: always taken.
- Other `1xxxx` opcodes are nops.
- Exactly one delay slot: the instruction at branch+2 always executes.
- Branches other than dec_bnez write no register.

**Register file and forwarding**
- 8×16 registers, cleared by reset.
- `16'h0000` is a nop and writes nothing.
- ID operands take the first match of:
  1. EX result, if the EX instruction writes a matching rX.
  2. WB register, if WB writes a matching rX.
  3. Register file.
- Stores and nops never forward.

**Stall**
- `stall = !i_ready | ((d_oe | d_we≠0) & !d_ready)`.
- While stalled, the following all hold their values: PC, every pipeline register, and the register-file write.
- While stalled, `i_addr`, `d_addr`, `d_we`, `d_dout` and `d_oe` stay stable. Memory must treat a repeated held write as idempotent.

**Counters**
- `cycle_cnt` increments every cycle out of reset.
- `stall_cnt` increments on stalled cycles.
- `instret_cnt` increments when a non-nop instruction leaves EX on an unstalled cycle.
- All counters wrap at 2^CNT_W.

## Timing
**Reset** (asynchronous assertion, synchronous release on the first clk edge with `rst_n=1`):
- PC and `i_addr` = `RESET_PC`.
- `i_oe`=0 while `rst_n`=0, 1 otherwise.
- IF/ID/EX instruction registers = `16'h0000`.
- `d_oe`=0, `d_we`=0, `d_addr`=0, `d_dout`=0.
- All counters = 0.
- Reset mid-stall or mid-store aborts immediately; `d_we` drops combinationally with `rst_n`.

**Pipeline**
- Fetch at cycle n is decoded at n+1, executes at n+2 (memory access is combinational in EX), and is written back at the n+3 edge.
- Back-to-back dependent ALU instructions, and a load followed by its consumer, need no stall.
- Taken branch: PC loads the target on the edge ending the branch's ID cycle, provided that cycle is unstalled.
- A branch stalled in ID re-evaluates its condition each cycle with current forwarding.
- Simultaneous `!i_ready` and `!d_ready`: a single stall cycle; `stall_cnt` increments by 1.

## Test plan
- **Reset / boot:** `RESET_PC`=0x0100 with `rst_n` pulsed low mid-cycle → `i_addr`=0x0100 asynchronously; first fetch at 0x0100; all counters 0.
- **Forwarding chain:** `addi r1,5; add r1,r1; add r1,r1` → r1=20; `instret_cnt`=3; no stall.
- **dec_bnez loop:** r2=3 with a loop body of 1 instruction plus the delay slot → loop executes 3 times; r2=0 at exit; fallthrough at branch+4.
- **Byte memory:** sbu r3 to addr 0x0201 with r3=0x12AB → `d_we`=`2'b10`, `d_dout`=0x00AB. Then lbu from 0x0200 with mem=0x5678 → 0x0056.
- **Wait states:** `d_ready` low for 3 cycles during lw → PC and `d_addr` held; `stall_cnt`=3; load value correct. `i_ready` low 2 cycles → same PC held.
- **Branch variants:** bmi on 0x8000 taken; bpl on 0x8000 not taken; j −4 loops → delay slot executes each pass.
